// File: rtl/matrix_stream_out_if.sv
// Handshake bundle for matrix_stream_out: parallel matrix capture side plus serial element side.
// master = producer/consumer environment, slave = the streaming block.
interface matrix_stream_out_if #(
   parameter int SIZE_A = 8,
   parameter int SIZE_B = 8,
   parameter int WIDTH  = 32
);
   localparam int RW = $clog2(SIZE_A) + 1;
   localparam int CW = $clog2(SIZE_B) + 1;

   logic                                      in_valid;
   logic                                      in_ready;
   logic [SIZE_A-1:0][SIZE_B-1:0][WIDTH-1:0]  mat_in;
   logic                                      out_valid;
   logic                                      out_ready;
   logic signed [WIDTH-1:0]                   elem_out;
   logic [RW-1:0]                             elem_row;
   logic [CW-1:0]                             elem_col;
   logic                                      elem_last;

   modport master (
      output in_valid, mat_in, out_ready,
      input  in_ready, out_valid, elem_out, elem_row, elem_col, elem_last
   );

   modport slave (
      input  in_valid, mat_in, out_ready,
      output in_ready, out_valid, elem_out, elem_row, elem_col, elem_last
   );
endinterface

// File: rtl/matrix_stream_out.sv
// Captures one SIZE_A x SIZE_B matrix per handshake and replays it as a tagged element stream,
// row-major (MODE 0) or column-major (MODE 1), counting delivered matrices.
module matrix_stream_out #(
   parameter int MODE   = 0,
   parameter int SIZE_A = 8,
   parameter int SIZE_B = 8,
   parameter int WIDTH  = 32,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   matrix_stream_out_if.slave    bus,
   output logic [CNT_W-1:0]      frame_cnt
);
   localparam int RW = $clog2(SIZE_A) + 1;
   localparam int CW = $clog2(SIZE_B) + 1;

   typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t                  state_r, state_nxt_s;
   logic [RW-1:0]           row_r, row_nxt_s;
   logic [CW-1:0]           col_r, col_nxt_s;
   logic [WIDTH-1:0]        mat_buf_r [SIZE_A][SIZE_B];
   logic signed [WIDTH-1:0] elem_r, elem_nxt_s, sel_s;
   logic                    in_ready_r, out_valid_r, last_r, last_nxt_s;
   logic [CNT_W-1:0]        frame_cnt_r;
   logic                    fire_in_s, fire_out_s, last_pos_s;

   // Next-state, read-out position and next element selection
   always_comb begin
      fire_in_s   = bus.in_valid && in_ready_r;
      fire_out_s  = out_valid_r && bus.out_ready;
      last_pos_s  = (row_r == RW'(SIZE_A - 1)) && (col_r == CW'(SIZE_B - 1));
      state_nxt_s = state_r;
      row_nxt_s   = row_r;
      col_nxt_s   = col_r;
      case (state_r)
         IDLE: begin
            if (fire_in_s) begin
               state_nxt_s = STREAM;
               row_nxt_s   = {RW{1'b0}};
               col_nxt_s   = {CW{1'b0}};
            end else begin
               state_nxt_s = IDLE;
            end
         end
         STREAM: begin
            if (fire_out_s && last_pos_s) begin
               state_nxt_s = IDLE;
               row_nxt_s   = {RW{1'b0}};
               col_nxt_s   = {CW{1'b0}};
            end else if (fire_out_s) begin
               // Inner index wraps into the outer one; outer order chosen by MODE
               if (MODE == 0) begin
                  if (col_r == CW'(SIZE_B - 1)) begin
                     col_nxt_s = {CW{1'b0}};
                     row_nxt_s = row_r + RW'(1);
                  end else begin
                     col_nxt_s = col_r + CW'(1);
                  end
               end else begin
                  if (row_r == RW'(SIZE_A - 1)) begin
                     row_nxt_s = {RW{1'b0}};
                     col_nxt_s = col_r + CW'(1);
                  end else begin
                     row_nxt_s = row_r + RW'(1);
                  end
               end
            end else begin
               state_nxt_s = STREAM;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            row_nxt_s   = {RW{1'b0}};
            col_nxt_s   = {CW{1'b0}};
         end
      endcase

      sel_s = mat_buf_r[0][0];
      for (int i = 0; i < SIZE_A; i++) begin
         for (int j = 0; j < SIZE_B; j++) begin
            sel_s = ((row_nxt_s == RW'(i)) && (col_nxt_s == CW'(j))) ? mat_buf_r[i][j] : sel_s;
         end
      end

      // On capture the buffer is not yet written, so the first element comes from mat_in
      if (fire_in_s) begin
         elem_nxt_s = bus.mat_in[0][0];
      end else if (fire_out_s && !last_pos_s) begin
         elem_nxt_s = sel_s;
      end else begin
         elem_nxt_s = elem_r;
      end

      last_nxt_s = (state_nxt_s == STREAM) &&
                   (row_nxt_s == RW'(SIZE_A - 1)) && (col_nxt_s == CW'(SIZE_B - 1));
   end

   // Control, position and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         row_r       <= {RW{1'b0}};
         col_r       <= {CW{1'b0}};
         elem_r      <= {WIDTH{1'b0}};
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         last_r      <= 1'b0;
         frame_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         row_r       <= row_nxt_s;
         col_r       <= col_nxt_s;
         elem_r      <= elem_nxt_s;
         in_ready_r  <= (state_nxt_s == IDLE);
         out_valid_r <= (state_nxt_s == STREAM);
         last_r      <= last_nxt_s;
         if (fire_out_s && last_pos_s) begin
            frame_cnt_r <= frame_cnt_r + CNT_W'(1);
         end else begin
            frame_cnt_r <= frame_cnt_r;
         end
      end
   end

   // Matrix buffer: written only on capture, contents need no reset
   always_ff @(posedge clk) begin
      if (fire_in_s) begin
         for (int i = 0; i < SIZE_A; i++) begin
            for (int j = 0; j < SIZE_B; j++) begin
               mat_buf_r[i][j] <= bus.mat_in[i][j];
            end
         end
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.elem_out  = elem_r;
   assign bus.elem_row  = row_r;
   assign bus.elem_col  = col_r;
   assign bus.elem_last = last_r;
   assign frame_cnt     = frame_cnt_r;
endmodule

// File: tb/tb_matrix_stream_out.sv
// Bench: row-major and column-major 2x3 instances share stimulus; a 1x1 CNT_W=4 instance
// exercises counter wrap. All are checked every cycle against a linear-index reference model.
module tb_matrix_stream_out;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                    in_valid, out_ready;
   logic [1:0][2:0][31:0]   mat;
   logic                    in_valid_c, out_ready_c;
   logic [31:0]             mat_c;
   logic [15:0]             fc_a, fc_b;
   logic [3:0]              fc_c;

   matrix_stream_out_if #(.SIZE_A(2), .SIZE_B(3), .WIDTH(32)) if_a ();
   matrix_stream_out_if #(.SIZE_A(2), .SIZE_B(3), .WIDTH(32)) if_b ();
   matrix_stream_out_if #(.SIZE_A(1), .SIZE_B(1), .WIDTH(32)) if_c ();

   assign if_a.in_valid  = in_valid;
   assign if_a.out_ready = out_ready;
   assign if_a.mat_in    = mat;
   assign if_b.in_valid  = in_valid;
   assign if_b.out_ready = out_ready;
   assign if_b.mat_in    = mat;
   assign if_c.in_valid  = in_valid_c;
   assign if_c.out_ready = out_ready_c;
   assign if_c.mat_in    = mat_c;

   matrix_stream_out #(.MODE(0), .SIZE_A(2), .SIZE_B(3), .WIDTH(32), .CNT_W(16))
      u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave), .frame_cnt(fc_a));
   matrix_stream_out #(.MODE(1), .SIZE_A(2), .SIZE_B(3), .WIDTH(32), .CNT_W(16))
      u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave), .frame_cnt(fc_b));
   matrix_stream_out #(.MODE(0), .SIZE_A(1), .SIZE_B(1), .WIDTH(32), .CNT_W(4))
      u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave), .frame_cnt(fc_c));

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: one matrix held as a flat row-major list, k counts elements delivered
   int          sa [3] = '{2, 2, 1};
   int          sb [3] = '{3, 3, 1};
   int          md [3] = '{0, 1, 0};
   int          cmod [3] = '{65536, 65536, 16};
   bit          busy [3];
   bit          pristine [3];
   int          k [3];
   int          cnt [3];
   logic [31:0] m [3][6];

   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         bit iv, ordy;
         iv   = (d < 2) ? in_valid : in_valid_c;
         ordy = (d < 2) ? out_ready : out_ready_c;
         if (!rst_n) begin
            busy[d] = 1'b0; pristine[d] = 1'b1; k[d] = 0; cnt[d] = 0;
         end else if (!busy[d]) begin
            if (iv) begin
               busy[d] = 1'b1; pristine[d] = 1'b0; k[d] = 0;
               for (int e = 0; e < sa[d] * sb[d]; e++)
                  m[d][e] = (d < 2) ? mat[e / 3][e % 3] : mat_c;
            end
         end else if (ordy) begin
            if (k[d] == sa[d] * sb[d] - 1) begin
               busy[d] = 1'b0; cnt[d] = (cnt[d] + 1) % cmod[d];
            end else begin
               k[d]++;
            end
         end
      end
   end

   task automatic chk_dut(input int d, input logic ir, input logic ov, input logic [31:0] el,
                          input logic [31:0] row, input logic [31:0] col, input logic last,
                          input logic [31:0] fc);
      int r, c;
      r = (md[d] == 0) ? k[d] / sb[d] : k[d] % sa[d];
      c = (md[d] == 0) ? k[d] % sb[d] : k[d] / sa[d];
      check_eq($sformatf("d%0d in_ready", d), {31'd0, ir}, {31'd0, !busy[d]});
      check_eq($sformatf("d%0d out_valid", d), {31'd0, ov}, {31'd0, busy[d]});
      check_eq($sformatf("d%0d elem_last", d), {31'd0, last},
               {31'd0, busy[d] && (k[d] == sa[d] * sb[d] - 1)});
      check_eq($sformatf("d%0d frame_cnt", d), fc, cnt[d]);
      if (busy[d]) begin
         check_eq($sformatf("d%0d elem_out", d), el, m[d][r * sb[d] + c]);
         check_eq($sformatf("d%0d elem_row", d), row, r);
         check_eq($sformatf("d%0d elem_col", d), col, c);
      end else if (pristine[d]) begin
         check_eq($sformatf("d%0d reset elem_out", d), el, 32'd0);
         check_eq($sformatf("d%0d reset elem_row", d), row, 32'd0);
         check_eq($sformatf("d%0d reset elem_col", d), col, 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk_dut(0, if_a.in_ready, if_a.out_valid, if_a.elem_out, 32'(if_a.elem_row),
                 32'(if_a.elem_col), if_a.elem_last, 32'(fc_a));
         chk_dut(1, if_b.in_ready, if_b.out_valid, if_b.elem_out, 32'(if_b.elem_row),
                 32'(if_b.elem_col), if_b.elem_last, 32'(fc_b));
         chk_dut(2, if_c.in_ready, if_c.out_valid, if_c.elem_out, 32'(if_c.elem_row),
                 32'(if_c.elem_col), if_c.elem_last, 32'(fc_c));
      end
   end

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 5))
         0: return 32'hFFFF_FFF9;
         1: return 32'h7FFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h0000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic new_mat();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 3; j++)
            mat[i][j] = pick_val();
      mat_c = pick_val();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mat = '0;
      in_valid_c = 1'b0; out_ready_c = 1'b0; mat_c = 32'd0;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed 2x3 {{1,2,3},{4,5,6}} plus 17+ back-to-back 1x1 matrices on the small instance
      for (int e = 0; e < 6; e++) mat[e / 3][e % 3] = 32'(e + 1);
      in_valid = 1'b1; out_ready = 1'b1;
      in_valid_c = 1'b1; out_ready_c = 1'b1; mat_c = 32'h8000_0001;
      @(posedge clk); #1;
      in_valid = 1'b0;
      mat = '0;
      repeat (40) @(posedge clk);
      #1;
      in_valid_c = 1'b0;

      // Abort a stream after three delivered elements
      for (int e = 0; e < 6; e++) mat[e / 3][e % 3] = 32'(10 * e - 20);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      new_mat();
      in_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;

      // Random traffic with backpressure, held in_valid and occasional resets
      for (int n = 0; n < 600; n++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         out_ready   = $urandom_range(0, 1) != 0;
         in_valid_c  = $urandom_range(0, 1) != 0;
         out_ready_c = $urandom_range(0, 1) != 0;
         rst_n       = ($urandom_range(0, 199) != 0);
         new_mat();
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
